// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single external memory port between two requesters:
//   requester 0 = packet loader (PL), requester 1 = memory-access unit (MA).
// One transaction is in flight at a time. A grant latches the request, the
// request is forwarded on the MEM_SEND channel, and for reads the response
// is captured and returned to the owning requester before the port is freed.
//
// Optional feature macro: MEM_ARB_LOCK_EN
//   defined   : the last owner keeps winning while it keeps requesting, up to
//               LOCK_MAX consecutive grants (keeps a packet load contiguous)
//   undefined : pure round-robin alternation between PL and MA
//
// Ports
//   CLK, RST                 clock (rising edge), async active-high reset
//   PL_SEND_* / MA_SEND_*    request channel per requester
//                            (ADDR_VALID, ADDR, DATA_VALID = write flag, DATA,
//                             READY = accepted, combinational)
//   PL_RECEIVE_* / MA_RECEIVE_*  read response channel per requester
//   MEM_SEND_*               request channel towards memory
//   MEM_RECEIVE_*            read data channel from memory
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LOCK_MAX   = 5
) (
  input  logic                  CLK,
  input  logic                  RST,

  input  logic                  PL_SEND_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] PL_SEND_ADDR,
  input  logic                  PL_SEND_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] PL_SEND_DATA,
  output logic                  PL_SEND_READY,
  output logic                  PL_RECEIVE_VALID,
  output logic [DATA_WIDTH-1:0] PL_RECEIVE_DATA,
  input  logic                  PL_RECEIVE_READY,

  input  logic                  MA_SEND_ADDR_VALID,
  input  logic [ADDR_WIDTH-1:0] MA_SEND_ADDR,
  input  logic                  MA_SEND_DATA_VALID,
  input  logic [DATA_WIDTH-1:0] MA_SEND_DATA,
  output logic                  MA_SEND_READY,
  output logic                  MA_RECEIVE_VALID,
  output logic [DATA_WIDTH-1:0] MA_RECEIVE_DATA,
  input  logic                  MA_RECEIVE_READY,

  output logic                  MEM_SEND_ADDR_VALID,
  output logic [ADDR_WIDTH-1:0] MEM_SEND_ADDR,
  output logic                  MEM_SEND_DATA_VALID,
  output logic [DATA_WIDTH-1:0] MEM_SEND_DATA,
  input  logic                  MEM_SEND_READY,
  input  logic                  MEM_RECEIVE_VALID,
  input  logic [DATA_WIDTH-1:0] MEM_RECEIVE_DATA,
  output logic                  MEM_RECEIVE_READY
);

  if (LOCK_MAX < 1) begin : g_bad_lock_max
    $error("mem_arbiter: LOCK_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic                    ptr_q;     // preferred requester on a tie: 0 = PL
  logic                    owner_q;   // requester of the current/last grant
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    wr_q;
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic                    grant;
  logic                    win_ma;    // winner of the current arbitration

`ifdef MEM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  logic [CW-1:0]           lock_cnt_q;
`endif

  // Arbitration, next-state and state-decoded outputs
  always_comb begin
    state_d             = state_q;
    grant               = 1'b0;
    win_ma              = 1'b0;
    PL_SEND_READY       = 1'b0;
    MA_SEND_READY       = 1'b0;
    PL_RECEIVE_VALID    = 1'b0;
    MA_RECEIVE_VALID    = 1'b0;
    MEM_SEND_ADDR_VALID = 1'b0;
    MEM_SEND_DATA_VALID = 1'b0;
    MEM_RECEIVE_READY   = 1'b0;

    if (PL_SEND_ADDR_VALID && MA_SEND_ADDR_VALID) begin
`ifdef MEM_ARB_LOCK_EN
      // Both requesting means the last owner is requesting again.
      win_ma = (lock_cnt_q < CW'(LOCK_MAX)) ? owner_q : ptr_q;
`else
      win_ma = ptr_q;
`endif
    end else begin
      win_ma = MA_SEND_ADDR_VALID;
    end

    case (state_q)
      ST_IDLE: begin
        grant         = PL_SEND_ADDR_VALID | MA_SEND_ADDR_VALID;
        PL_SEND_READY = grant & ~win_ma;
        MA_SEND_READY = grant & win_ma;
        if (grant) state_d = ST_SEND;
      end
      ST_SEND: begin
        MEM_SEND_ADDR_VALID = 1'b1;
        MEM_SEND_DATA_VALID = wr_q;
        if (MEM_SEND_READY) state_d = wr_q ? ST_IDLE : ST_WAIT;
      end
      ST_WAIT: begin
        MEM_RECEIVE_READY = 1'b1;
        if (MEM_RECEIVE_VALID) state_d = ST_RESP;
      end
      ST_RESP: begin
        PL_RECEIVE_VALID = ~owner_q;
        MA_RECEIVE_VALID = owner_q;
        if (owner_q ? MA_RECEIVE_READY : PL_RECEIVE_READY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign MEM_SEND_ADDR   = addr_q;
  assign MEM_SEND_DATA   = data_q;
  assign PL_RECEIVE_DATA = rdata_q;
  assign MA_RECEIVE_DATA = rdata_q;

  // State, grant latch and response capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ptr_q   <= ~win_ma;   // the other requester is preferred next time
        owner_q <= win_ma;
        addr_q  <= win_ma ? MA_SEND_ADDR       : PL_SEND_ADDR;
        data_q  <= win_ma ? MA_SEND_DATA       : PL_SEND_DATA;
        wr_q    <= win_ma ? MA_SEND_DATA_VALID : PL_SEND_DATA_VALID;
      end
      if (state_q == ST_WAIT && MEM_RECEIVE_VALID) begin
        rdata_q <= MEM_RECEIVE_DATA;
      end
    end
  end

`ifdef MEM_ARB_LOCK_EN
  // Consecutive-grant counter; owner_q still holds the previous owner here.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lock_cnt_q <= '0;
    end else if (grant) begin
      if (win_ma != owner_q) begin
        lock_cnt_q <= CW'(1);
      end else if (lock_cnt_q < CW'(LOCK_MAX)) begin
        lock_cnt_q <= lock_cnt_q + CW'(1);
      end
    end
  end
`endif

endmodule
